// File: rtl/oh_arbmux_pkg.sv
// Shared constants and helpers for the one-hot round-robin arbiter/mux.
// Default channel width/count and the log2 helper used to size the pointer.
package oh_arbmux_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_M = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/oh_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant of the lowest requester at
// or above ptr, otherwise the lowest requester below ptr.
module oh_arbiter_rr
  import oh_arbmux_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int PW = clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  grant
);

  logic [M-1:0] hi_req;
  logic         hi_found;
  logic         lo_found;

  always_comb begin
    grant    = '0;
    hi_req   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < M; i++) hi_req[i] = req[i] && (i >= int'(ptr));
    for (int i = 0; i < M; i++) begin
      if (hi_req[i] && !hi_found) begin
        grant[i] = 1'b1;
        hi_found = 1'b1;
      end
    end
    // Nothing at or above ptr: wrap to the lowest requester overall.
    if (!hi_found) begin
      for (int i = 0; i < M; i++) begin
        if (req[i] && !lo_found) begin
          grant[i] = 1'b1;
          lo_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oh_arbmux.sv
// Round-robin M:1 arbiter/mux with a single registered output stage.
// Define OH_ARBMUX_LOCK_EN to add packet lock (in_last / out_last ports).
module oh_arbmux
  import oh_arbmux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [M-1:0]   out_sel,
  input  logic           out_ready
`ifdef OH_ARBMUX_LOCK_EN
  ,
  input  logic [M-1:0]   in_last,
  output logic           out_last
`endif
);

  localparam int PW = clog2(M);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt_p0;
  logic [M-1:0]  arb_grant;
  logic [M-1:0]  grant_p0;
  logic          open_p0;
  logic          xfer_p0;
  logic [N-1:0]  mux_data_p0;
`ifdef OH_ARBMUX_LOCK_EN
  logic          lock;
  logic [M-1:0]  lock_sel;
  logic          last_p0;
`endif

  oh_arbiter_rr #(.M(M), .PW(PW)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  // Stage p0: grant, handshake and one-hot AND-OR select
  always_comb begin
`ifdef OH_ARBMUX_LOCK_EN
    grant_p0 = lock ? (lock_sel & in_valid) : arb_grant;
    last_p0  = |(in_ready & in_last);
`else
    grant_p0 = arb_grant;
`endif
    open_p0     = !out_valid || out_ready;
    in_ready    = grant_p0 & {M{open_p0 && !reset}};
    xfer_p0     = |in_ready;
    mux_data_p0 = '0;
    ptr_nxt_p0  = ptr;
    for (int i = 0; i < M; i++) begin
      mux_data_p0 = mux_data_p0 | (in_data[i*N +: N] & {N{in_ready[i]}});
      if (in_ready[i]) ptr_nxt_p0 = (i == M-1) ? '0 : PW'(i + 1);
    end
  end

  // Stage p1: output register, pointer and lock state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef OH_ARBMUX_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_sel  <= '0;
`endif
    end else if (xfer_p0) begin
      out_valid <= 1'b1;
      out_data  <= mux_data_p0;
      out_sel   <= in_ready;
`ifdef OH_ARBMUX_LOCK_EN
      out_last  <= last_p0;
      lock      <= !last_p0;
      lock_sel  <= in_ready;
      // Pointer advances only once the packet completes.
      if (last_p0) ptr <= ptr_nxt_p0;
`else
      ptr       <= ptr_nxt_p0;
`endif
    end else if (open_p0) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oh_arbmux.sv
// Bench for oh_arbmux (N=8, M=4): directed vector table plus randomized traffic
// against a queue-free behavioural model of the round-robin handshake.
module tb_oh_arbmux;

  localparam int N = 8;
  localparam int M = 4;
`ifdef OH_ARBMUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [M-1:0]   out_sel;
  logic           out_ready;
  logic [M-1:0]   in_last;
`ifdef OH_ARBMUX_LOCK_EN
  logic           out_last;
`endif

  oh_arbmux #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef OH_ARBMUX_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration state as plain integers
  int          m_ptr, m_lch;
  bit          m_ov, m_lock, m_ol;
  logic [N-1:0] m_od;
  logic [M-1:0] m_os;

  function automatic logic [M-1:0] m_ready();
    logic [M-1:0] g;
    g = '0;
    if (reset) return g;
    if (m_ov && !out_ready) return g;
    if (m_lock) begin
      if (in_valid[m_lch]) g[m_lch] = 1'b1;
      return g;
    end
    for (int k = 0; k < M; k++) begin
      int idx;
      idx = (m_ptr + k) % M;
      if (in_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic m_update(input logic [M-1:0] rdy);
    int ch;
    ch = 0;
    if (reset) begin
      m_ptr = 0; m_lch = 0; m_ov = 0; m_lock = 0; m_ol = 0; m_od = '0; m_os = '0;
    end else if (rdy != '0) begin
      for (int k = 0; k < M; k++) if (rdy[k]) ch = k;
      m_od = in_data[ch*N +: N];
      m_os = rdy;
      m_ov = 1;
      m_ol = LOCK && in_last[ch];
      if (LOCK && !in_last[ch]) begin
        m_lock = 1; m_lch = ch;
      end else begin
        m_lock = 0; m_ptr = (ch + 1) % M;
      end
    end else if (!m_ov || out_ready) begin
      m_ov = 0;
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  iv;
    bit          ordy;
    bit          a5;
    logic [3:0]  er;
    bit          ev;
    logic [7:0]  ed;
    logic [3:0]  es;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] iv, bit ordy, bit a5,
                              logic [3:0] er, bit ev, logic [7:0] ed, logic [3:0] es);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ordy = ordy; v.a5 = a5;
    v.er = er; v.ev = ev; v.ed = ed; v.es = es;
    return v;
  endfunction

  // mode 0: model only; 1: plus in_ready vs v.er; 2: plus all table fields
  task automatic cyc(input int mode, input vec_t v);
    logic [M-1:0] r;
    @(negedge clk);
    r = m_ready();
    chk("model_in_ready", in_ready, r);
    chk("model_out_valid", out_valid, m_ov);
    chk("model_out_data", out_data, m_od);
    chk("model_out_sel", out_sel, m_os);
`ifdef OH_ARBMUX_LOCK_EN
    chk("model_out_last", out_last, m_ol);
`endif
    if (mode >= 1) chk("vec_in_ready", in_ready, v.er);
    if (mode >= 2) begin
      chk("vec_out_valid", out_valid, v.ev);
      chk("vec_out_data", out_data, v.ed);
      chk("vec_out_sel", out_sel, v.es);
    end
    @(posedge clk);
    m_update(r);
    #1;
  endtask

  vec_t tbl[$];
  vec_t nv;

  initial begin
    nv = mk(0, 4'h0, 0, 0, 4'h0, 0, 8'h00, 4'h0);
    // Reset state, full-rate rotation, single channel stall, wrap, idle, reset mid-stream
    tbl.push_back(mk(1, 4'hF, 1, 0, 4'h0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h1, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h2, 1, 8'h10, 4'h1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h4, 1, 8'h11, 4'h2));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h8, 1, 8'h12, 4'h4));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h1, 1, 8'h13, 4'h8));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h2, 1, 8'h10, 4'h1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h4, 1, 8'h11, 4'h2));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h8, 1, 8'h12, 4'h4));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 8'h13, 4'h8));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 8'h13, 4'h8));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h4, 0, 8'h13, 4'h8));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 1, 8'hA5, 4'h4));
    tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 1, 8'hA5, 4'h4));
    tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 8'hA5, 4'h4));
    tbl.push_back(mk(0, 4'h3, 1, 0, 4'h1, 0, 8'hA5, 4'h4));
    tbl.push_back(mk(0, 4'h3, 1, 0, 4'h2, 1, 8'h10, 4'h1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 8'h11, 4'h2));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 8'h11, 4'h2));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h4, 0, 8'h11, 4'h2));
    tbl.push_back(mk(0, 4'h0, 0, 0, 4'h0, 1, 8'h12, 4'h4));
    tbl.push_back(mk(1, 4'hF, 0, 0, 4'h0, 1, 8'h12, 4'h4));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h1, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h2, 1, 8'h10, 4'h1));

    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1; in_last = '1;
    repeat (2) @(posedge clk);
    #1;
    m_update('0);

    foreach (tbl[i]) begin
      reset     = tbl[i].rst;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].a5 ? 32'h13A5_1110 : 32'h1312_1110;
      in_last   = '1;
      cyc(2, tbl[i]);
    end

    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      in_valid  = M'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_last   = LOCK ? M'($urandom) : '1;
      cyc(0, nv);
    end

`ifdef OH_ARBMUX_LOCK_EN
    // Packet lock: ch1 three-beat packet with a two-cycle gap, ch0/ch3 competing
    reset = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = 32'h4333_2210;
    cyc(0, nv);
    reset = 1'b0;
    in_valid = 4'b0001; in_last = 4'b0001; nv.er = 4'b0001; cyc(1, nv);
    in_valid = 4'b1011; in_last = 4'b0000; nv.er = 4'b0010; cyc(1, nv);
    in_valid = 4'b1001;                    nv.er = 4'b0000; cyc(1, nv);
    cyc(1, nv);
    in_valid = 4'b1011;                    nv.er = 4'b0010; cyc(1, nv);
    in_last  = 4'b0010;                    cyc(1, nv);
    in_valid = 4'b1001; in_last = 4'b1111; nv.er = 4'b1000; cyc(1, nv);
    nv.er = 4'b0001; cyc(1, nv);
    in_valid = '0; nv.er = 4'b0000; cyc(1, nv);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
